// File: rtl/truth_table_sweeper.sv
// Exhaustive stimulus sequencer: drives every input vector to a small combinational unit,
// records its 1-bit response and compares the result with an expected table. Optional macro: TT_SWEEP_STOP_ON_FAIL_EN.
module truth_table_sweeper #(
    parameter int N_IN   = 2,
    parameter int SETTLE = 1
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   start,
    input  logic [(1<<N_IN)-1:0]   exp_table,
    input  logic                   dut_out,
    output logic [N_IN-1:0]        dut_in,
    output logic                   busy,
    output logic                   done,
    output logic                   pass,
    output logic [N_IN-1:0]        fail_idx,
    output logic [(1<<N_IN)-1:0]   captured
);

    localparam int NV = 1 << N_IN;
    localparam logic [N_IN:0] LAST_IDX = (N_IN+1)'(NV - 1);
    localparam logic [3:0]    SETTLE_W = 4'(SETTLE);
    localparam logic [N_IN:0] IDX_ONE  = {{N_IN{1'b0}}, 1'b1};

    typedef enum logic [0:0] {IDLE = 1'b0, HOLD = 1'b1} state_t;

    state_t          state_q, state_d;
    logic [N_IN:0]   idx_q, idx_d;
    logic [3:0]      settle_q, settle_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            pass_q, pass_d;
    logic            mism_q, mism_d;
    logic [N_IN-1:0] fail_idx_q, fail_idx_d;
    logic [NV-1:0]   captured_q, captured_d;
    logic [NV-1:0]   exp_q, exp_d;
    logic            mis_s;
    logic            stop_s;

    // Next-state logic: start acceptance, settle counting and per-vector sampling.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        settle_d   = settle_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        pass_d     = pass_q;
        mism_d     = mism_q;
        fail_idx_d = fail_idx_q;
        captured_d = captured_q;
        exp_d      = exp_q;
        mis_s      = 1'b0;
        stop_s     = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d    = HOLD;
                    exp_d      = exp_table;
                    captured_d = '0;
                    pass_d     = 1'b0;
                    mism_d     = 1'b0;
                    fail_idx_d = '0;
                    idx_d      = '0;
                    settle_d   = 4'd0;
                    busy_d     = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            HOLD: begin
                if (settle_q == SETTLE_W) begin
                    captured_d[idx_q[N_IN-1:0]] = dut_out;
                    mis_s    = (dut_out != exp_q[idx_q[N_IN-1:0]]);
                    settle_d = 4'd0;
                    if (mis_s && !mism_q) begin
                        mism_d     = 1'b1;
                        fail_idx_d = idx_q[N_IN-1:0];
                    end else begin
                        mism_d = mism_q;
                    end
`ifdef TT_SWEEP_STOP_ON_FAIL_EN
                    stop_s = (idx_q == LAST_IDX) || mis_s;
`else
                    stop_s = (idx_q == LAST_IDX);
`endif
                    if (stop_s) begin
                        // Compare against the table including the bit sampled on this edge.
                        state_d = IDLE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        idx_d   = '0;
                        pass_d  = (captured_d == exp_q);
                    end else begin
                        idx_d = idx_q + IDX_ONE;
                    end
                end else begin
                    settle_d = settle_q + 4'd1;
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
                idx_d   = '0;
            end
        endcase
    end

    // State and output registers, cleared asynchronously.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            settle_q   <= 4'd0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
            mism_q     <= 1'b0;
            fail_idx_q <= '0;
            captured_q <= '0;
            exp_q      <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            settle_q   <= settle_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            pass_q     <= pass_d;
            mism_q     <= mism_d;
            fail_idx_q <= fail_idx_d;
            captured_q <= captured_d;
            exp_q      <= exp_d;
        end
    end

    assign dut_in   = idx_q[N_IN-1:0];
    assign busy     = busy_q;
    assign done     = done_q;
    assign pass     = pass_q;
    assign fail_idx = fail_idx_q;
    assign captured = captured_q;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Self-checking bench for truth_table_sweeper: directed vector table, random sweeps against
// a table-level model, and hand sequences for restart, reset abort and SETTLE=0.
module tb_truth_table_sweeper;

    localparam int S = 1;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       start = 1'b0;
    logic [3:0] exp_table = 4'b0000;
    logic [3:0] unit_tt = 4'b1000;
    logic       dut_out;
    logic [1:0] dut_in, fail_idx;
    logic       busy, done, pass;
    logic [3:0] captured;

    logic       start0 = 1'b0;
    logic [3:0] exp0 = 4'b0000;
    logic       dut_out0;
    logic [1:0] dut_in0, fail_idx0;
    logic       busy0, done0, pass0;
    logic [3:0] captured0;

    int n_cmp = 0;
    int n_err = 0;

    assign dut_out  = unit_tt[dut_in];
    assign dut_out0 = dut_in0[0] & dut_in0[1];

    always #5 clk = ~clk;

    truth_table_sweeper #(.N_IN(2), .SETTLE(S)) u_dut (
        .clk(clk), .reset_n(reset_n), .start(start), .exp_table(exp_table),
        .dut_out(dut_out), .dut_in(dut_in), .busy(busy), .done(done),
        .pass(pass), .fail_idx(fail_idx), .captured(captured)
    );

    truth_table_sweeper #(.N_IN(2), .SETTLE(0)) u_dut0 (
        .clk(clk), .reset_n(reset_n), .start(start0), .exp_table(exp0),
        .dut_out(dut_out0), .dut_in(dut_in0), .busy(busy0), .done(done0),
        .pass(pass0), .fail_idx(fail_idx0), .captured(captured0)
    );

    typedef struct {
        logic [3:0] u;
        logic [3:0] e;
        logic [3:0] cap;
        logic       ps;
        logic [1:0] fi;
        int         lat;
        int         pulse;
    } vec_t;

    vec_t tbl[6];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h required %0h at %0t", nm, act, req, $time);
        end
    endtask

    // Reference: per-vector result is simply the unit's own truth table, sweep ends early only on stop-on-fail.
    task automatic model(input logic [3:0] u, input logic [3:0] e, output logic [3:0] cap,
                         output logic ps, output logic [1:0] fi, output int lat);
        bit found = 1'b0;
        fi = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (!found && (u[i] != e[i])) begin
                found = 1'b1;
                fi = 2'(i);
            end
        end
        ps  = (u == e);
        cap = u;
        lat = 4 * (S + 1);
`ifdef TT_SWEEP_STOP_ON_FAIL_EN
        if (found) begin
            for (int i = 0; i < 4; i++) cap[i] = (i <= int'(fi)) ? u[i] : 1'b0;
            lat = (int'(fi) + 1) * (S + 1);
        end
`endif
    endtask

    task automatic sweep(input logic [3:0] u, input logic [3:0] e, input logic [3:0] cap,
                         input logic ps, input logic [1:0] fi, input int lat, input int pulse,
                         input bit started, input bit chain, input logic [3:0] nu,
                         input logic [3:0] ne, input string nm);
        if (!started) begin
            @(negedge clk);
            unit_tt   = u;
            exp_table = e;
            start     = 1'b1;
        end
        @(negedge clk);
        start     = 1'b0;
        exp_table = ~e;
        chk({nm, " cleared"}, {28'd0, pass, fail_idx, 1'b0} | {28'd0, captured}, 32'd0);
        for (int c = 0; c < lat; c++) begin
            chk({nm, " trace"}, {29'd0, busy, done, 1'b0} | {30'd0, dut_in},
                {29'd0, 1'b1, 1'b0, 1'b0} | 32'(c / (S + 1)));
            if (c == pulse) begin
                start = 1'b1;
            end
            if (c == pulse + 1) begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        chk({nm, " done"}, {29'd0, busy, done, 1'b0} | {30'd0, dut_in}, 32'h2);
        chk({nm, " captured"}, {28'd0, captured}, {28'd0, cap});
        chk({nm, " pass"}, {31'd0, pass}, {31'd0, ps});
        chk({nm, " fail_idx"}, {30'd0, fail_idx}, {30'd0, fi});
        if (chain) begin
            unit_tt   = nu;
            exp_table = ne;
            start     = 1'b1;
        end else begin
            @(negedge clk);
            chk({nm, " after"}, {30'd0, busy, done}, 32'd0);
            chk({nm, " pass hold"}, {31'd0, pass}, {31'd0, ps});
        end
    endtask

    initial begin
        logic [3:0] u, e, cap;
        logic       ps;
        logic [1:0] fi;
        int         lat;
        bit         seen;

        tbl[0] = '{u: 4'b1000, e: 4'b1000, cap: 4'b1000, ps: 1'b1, fi: 2'd0, lat: 8, pulse: -5};
`ifdef TT_SWEEP_STOP_ON_FAIL_EN
        tbl[1] = '{u: 4'b1000, e: 4'b1110, cap: 4'b0000, ps: 1'b0, fi: 2'd1, lat: 4, pulse: -5};
        tbl[4] = '{u: 4'b0000, e: 4'b0001, cap: 4'b0000, ps: 1'b0, fi: 2'd0, lat: 2, pulse: -5};
`else
        tbl[1] = '{u: 4'b1000, e: 4'b1110, cap: 4'b1000, ps: 1'b0, fi: 2'd1, lat: 8, pulse: -5};
        tbl[4] = '{u: 4'b0000, e: 4'b0001, cap: 4'b0000, ps: 1'b0, fi: 2'd0, lat: 8, pulse: -5};
`endif
        tbl[2] = '{u: 4'b0110, e: 4'b0110, cap: 4'b0110, ps: 1'b1, fi: 2'd0, lat: 8, pulse: -5};
        tbl[3] = '{u: 4'b1000, e: 4'b0000, cap: 4'b1000, ps: 1'b0, fi: 2'd3, lat: 8, pulse: -5};
        tbl[5] = '{u: 4'b1000, e: 4'b1000, cap: 4'b1000, ps: 1'b1, fi: 2'd0, lat: 8, pulse: 3};

        repeat (3) @(negedge clk);
        chk("reset outputs", {22'd0, busy, done, pass, fail_idx, captured, dut_in}, 32'd0);
        reset_n = 1'b1;

        for (int i = 0; i < 6; i++) begin
            sweep(tbl[i].u, tbl[i].e, tbl[i].cap, tbl[i].ps, tbl[i].fi, tbl[i].lat,
                  tbl[i].pulse, 1'b0, 1'b0, 4'd0, 4'd0, $sformatf("vec%0d", i));
        end

        for (int i = 0; i < 20; i++) begin
            u = 4'($urandom);
            e = ($urandom_range(1) == 0) ? u : 4'($urandom);
            model(u, e, cap, ps, fi, lat);
            sweep(u, e, cap, ps, fi, lat, -5, 1'b0, 1'b0, 4'd0, 4'd0, $sformatf("rnd%0d", i));
        end

        // Back-to-back sweep: start already high in the done cycle.
        model(4'b1000, 4'b1000, cap, ps, fi, lat);
        sweep(4'b1000, 4'b1000, cap, ps, fi, lat, -5, 1'b0, 1'b1, 4'b1000, 4'b1110, "chain1");
        model(4'b1000, 4'b1110, cap, ps, fi, lat);
        sweep(4'b1000, 4'b1110, cap, ps, fi, lat, -5, 1'b1, 1'b0, 4'd0, 4'd0, "chain2");

        // Reset abort while vector 2 is being driven.
        @(negedge clk);
        unit_tt   = 4'b1000;
        exp_table = 4'b1000;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        seen  = 1'b0;
        for (int c = 0; c < 12 && !seen; c++) begin
            if (dut_in == 2'd2) seen = 1'b1;
            else @(negedge clk);
        end
        chk("reach vector 2", {31'd0, seen}, 32'd1);
        #2 reset_n = 1'b0;
        #1 chk("async abort", {22'd0, busy, done, pass, fail_idx, captured, dut_in}, 32'd0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("no done in reset", {31'd0, done}, 32'd0);
        end
        reset_n = 1'b1;
        sweep(4'b1000, 4'b1000, 4'b1000, 1'b1, 2'd0, 8, -5, 1'b0, 1'b0, 4'd0, 4'd0, "restart");

        // SETTLE=0 instance: one cycle per vector.
        @(negedge clk);
        exp0   = 4'b1000;
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        for (int c = 0; c < 4; c++) begin
            chk("s0 trace", {29'd0, busy0, done0, 1'b0} | {30'd0, dut_in0},
                {29'd0, 1'b1, 1'b0, 1'b0} | 32'(c));
            @(negedge clk);
        end
        chk("s0 done", {24'd0, busy0, done0, pass0, fail_idx0, captured0[2:0]} | {28'd0, captured0},
            {24'd0, 1'b0, 1'b1, 1'b1, 2'd0, 3'b000} | 32'h8);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
